// File: rtl/lsu_stb_fifo.sv
// LSU store buffer: DEPTH-entry circular queue of committed stores with in-order
// drain to dmem, youngest-match store-to-load forwarding and a fence/drain handshake.
module lsu_stb_fifo #(
    parameter int unsigned  DEPTH  = 4,
    parameter int unsigned  ADDR_W = 32,
    parameter int unsigned  DATA_W = 32,
    localparam int unsigned BE_W   = DATA_W / 8,
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_req_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [BE_W-1:0]   st_be_i,
    output logic              st_ack_o,
    output logic              st_stall_o,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [BE_W-1:0]   ld_be_i,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic              fwd_stall_o,
    output logic              dm_req_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [DATA_W-1:0] dm_data_o,
    output logic [BE_W-1:0]   dm_be_o,
    input  logic              dm_ack_i,
    input  logic              fence_i,
    output logic              fence_done_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {RUN, FENCE, DONE} state_t;

    state_t            state_q, state_d;
    logic              run;

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [BE_W-1:0]   ent_be   [DEPTH];
    logic [DEPTH-1:0]  ent_valid;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push, pop;

    logic [PTR_W-1:0]  slot;
    logic              yng_found;
    logic [BE_W-1:0]   yng_be;
    logic [DATA_W-1:0] yng_data;
    logic              overlap;
    logic              covered;

    // Fence FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Fence FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (fence_i) state_d = FENCE;
            FENCE:   if (count_q == '0) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Fence FSM: outputs
    always_comb begin
        run          = 1'b0;
        fence_done_o = 1'b0;
        case (state_q)
            RUN:     run = 1'b1;
            DONE:    fence_done_o = 1'b1;
            default: ;
        endcase
    end

    // Full is taken from the registered count, so a same-cycle drain never admits a store.
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

    assign st_ack_o   = st_req_i & ~full_o & run;
    assign st_stall_o = st_req_i & ~st_ack_o;
    assign push       = st_ack_o;

    assign dm_req_o   = ~empty_o;
    assign pop        = dm_req_o & dm_ack_i;

    assign dm_addr_o  = dm_req_o ? ent_addr[rd_ptr] : '0;
    assign dm_data_o  = dm_req_o ? ent_data[rd_ptr] : '0;
    assign dm_be_o    = dm_req_o ? ent_be[rd_ptr]   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            ent_valid <= '0;
        end else begin
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= st_addr_i;
            ent_data[wr_ptr] <= st_data_i;
            ent_be[wr_ptr]   <= st_be_i;
        end
    end

    // Walk entries oldest to youngest from rd_ptr; the last match seen is the youngest.
    always_comb begin
        slot      = '0;
        yng_found = 1'b0;
        yng_be    = '0;
        yng_data  = '0;
        overlap   = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot = rd_ptr + PTR_W'(k);
            if (ent_valid[slot] &&
                (ent_addr[slot][ADDR_W-1:OFF_W] == ld_addr_i[ADDR_W-1:OFF_W])) begin
                yng_found = 1'b1;
                yng_be    = ent_be[slot];
                yng_data  = ent_data[slot];
                if ((ent_be[slot] & ld_be_i) != '0) begin
                    overlap = 1'b1;
                end
            end
        end
    end

    assign covered     = yng_found & ((yng_be & ld_be_i) == ld_be_i);
    assign fwd_hit_o   = ld_req_i & covered;
    assign fwd_data_o  = fwd_hit_o ? yng_data : '0;
    assign fwd_stall_o = ld_req_i & ~covered & overlap;

    generate
        if (OFF_W > 0) begin : g_off
            logic unused_ld_off;
            assign unused_ld_off = ^ld_addr_i[OFF_W-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_lsu_stb_fifo.sv
// Directed bench for lsu_stb_fifo (DEPTH=4): table of per-cycle vectors plus
// hand-written fence, wrap-around and reset-mid-drain sequences.
module tb_lsu_stb_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = 4;
    localparam int unsigned CW    = 3;

    logic          clk;
    logic          rst_n;
    logic          st_req;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [BW-1:0] st_be;
    logic          st_ack, st_stall;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [BW-1:0] ld_be;
    logic          fwd_hit, fwd_stall;
    logic [DW-1:0] fwd_data;
    logic          dm_req, dm_ack;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_data;
    logic [BW-1:0] dm_be;
    logic          fence, fence_done;
    logic [CW-1:0] count;
    logic          full, empty;

    int n_chk = 0;
    int n_err = 0;

    lsu_stb_fifo #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_req_i(st_req), .st_addr_i(st_addr), .st_data_i(st_data), .st_be_i(st_be),
        .st_ack_o(st_ack), .st_stall_o(st_stall),
        .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_be_i(ld_be),
        .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data), .fwd_stall_o(fwd_stall),
        .dm_req_o(dm_req), .dm_addr_o(dm_addr), .dm_data_o(dm_data), .dm_be_o(dm_be),
        .dm_ack_i(dm_ack), .fence_i(fence), .fence_done_o(fence_done),
        .count_o(count), .full_o(full), .empty_o(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    typedef struct {
        logic          st_req;
        logic [AW-1:0] st_addr;
        logic [DW-1:0] st_data;
        logic [BW-1:0] st_be;
        logic          ld_req;
        logic [AW-1:0] ld_addr;
        logic [BW-1:0] ld_be;
        logic          dm_ack;
        logic          e_ack;
        logic          e_stall;
        logic          e_hit;
        logic [DW-1:0] e_fdata;
        logic          e_fstall;
        logic          e_dmreq;
        logic [AW-1:0] e_dmaddr;
        logic [DW-1:0] e_dmdata;
        logic [CW-1:0] e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] sr, sa, sd, sb, lr, la, lb, da,
                       input logic [31:0] eack, estall, ehit, efd, efs, edr, eda, edd, ec);
        vec_t v;
        v.st_req = sr[0];      v.st_addr = sa;        v.st_data = sd;     v.st_be = sb[BW-1:0];
        v.ld_req = lr[0];      v.ld_addr = la;        v.ld_be = lb[BW-1:0];
        v.dm_ack = da[0];
        v.e_ack = eack[0];     v.e_stall = estall[0]; v.e_hit = ehit[0];  v.e_fdata = efd;
        v.e_fstall = efs[0];   v.e_dmreq = edr[0];    v.e_dmaddr = eda;   v.e_dmdata = edd;
        v.e_count = ec[CW-1:0];
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic sr, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic da, input logic fe);
        st_req  = sr;
        st_addr = sa;
        st_data = sd;
        st_be   = 4'hF;
        ld_req  = 1'b0;
        ld_addr = '0;
        ld_be   = '0;
        dm_ack  = da;
        fence   = fe;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int done_pulses;

    initial begin
        rst_n = 1'b0;
        drv(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset empty", empty, 1);
        chk("reset full", full, 0);
        chk("reset count", count, 0);
        chk("reset dm_req", dm_req, 0);
        chk("reset dm_addr", dm_addr, 0);
        chk("reset fence_done", fence_done, 0);
        chk("reset st_ack", st_ack, 0);
        rst_n = 1'b1;
        #2;

        //  st  addr        data          be    ld  laddr    lbe  dma  ack stl hit fdata         fst dreq daddr    ddata         cnt
        add(0, 0,          0,            0,    0,  0,       0,   0,   0,  0,  0,  0,            0,  0,   0,       0,            0);
        add(1, 'h100,      'h11,         'hF,  0,  0,       0,   0,   1,  0,  0,  0,            0,  0,   0,       0,            0);
        add(1, 'h104,      'h22,         'hF,  0,  0,       0,   0,   1,  0,  0,  0,            0,  1,   'h100,   'h11,         1);
        add(1, 'h108,      'h33,         'hF,  0,  0,       0,   0,   1,  0,  0,  0,            0,  1,   'h100,   'h11,         2);
        add(1, 'h10C,      'h44,         'hF,  0,  0,       0,   0,   1,  0,  0,  0,            0,  1,   'h100,   'h11,         3);
        add(1, 'h110,      'h55,         'hF,  0,  0,       0,   0,   0,  1,  0,  0,            0,  1,   'h100,   'h11,         4);
        add(1, 'h110,      'h55,         'hF,  0,  0,       0,   1,   0,  1,  0,  0,            0,  1,   'h100,   'h11,         4);
        add(1, 'h110,      'h55,         'hF,  0,  0,       0,   0,   1,  0,  0,  0,            0,  1,   'h104,   'h22,         3);
        add(0, 0,          0,            0,    0,  0,       0,   1,   0,  0,  0,  0,            0,  1,   'h104,   'h22,         4);
        add(0, 0,          0,            0,    0,  0,       0,   1,   0,  0,  0,  0,            0,  1,   'h108,   'h33,         3);
        add(0, 0,          0,            0,    0,  0,       0,   1,   0,  0,  0,  0,            0,  1,   'h10C,   'h44,         2);
        add(0, 0,          0,            0,    0,  0,       0,   1,   0,  0,  0,  0,            0,  1,   'h110,   'h55,         1);
        add(0, 0,          0,            0,    0,  0,       0,   0,   0,  0,  0,  0,            0,  0,   0,       0,            0);
        add(1, 'h200,      'hAAAAAAAA,   'hF,  0,  0,       0,   0,   1,  0,  0,  0,            0,  0,   0,       0,            0);
        add(1, 'h200,      'h5555,       'h3,  1,  'h200,   'h3, 0,   1,  0,  1,  'hAAAAAAAA,   0,  1,   'h200,   'hAAAAAAAA,   1);
        add(0, 0,          0,            0,    1,  'h200,   'h3, 0,   0,  0,  1,  'h5555,       0,  1,   'h200,   'hAAAAAAAA,   2);
        add(0, 0,          0,            0,    1,  'h200,   'hC, 0,   0,  0,  0,  0,            1,  1,   'h200,   'hAAAAAAAA,   2);
        add(0, 0,          0,            0,    1,  'h300,   'hF, 0,   0,  0,  0,  0,            0,  1,   'h200,   'hAAAAAAAA,   2);
        add(0, 0,          0,            0,    0,  'h200,   'h3, 0,   0,  0,  0,  0,            0,  1,   'h200,   'hAAAAAAAA,   2);
        add(0, 0,          0,            0,    1,  'h202,   'h3, 0,   0,  0,  1,  'h5555,       0,  1,   'h200,   'hAAAAAAAA,   2);
        add(0, 0,          0,            0,    0,  0,       0,   1,   0,  0,  0,  0,            0,  1,   'h200,   'hAAAAAAAA,   2);
        add(0, 0,          0,            0,    1,  'h200,   'hC, 0,   0,  0,  0,  0,            0,  1,   'h200,   'h5555,       1);
        add(0, 0,          0,            0,    1,  'h200,   'h1, 0,   0,  0,  1,  'h5555,       0,  1,   'h200,   'h5555,       1);
        add(0, 0,          0,            0,    0,  0,       0,   1,   0,  0,  0,  0,            0,  1,   'h200,   'h5555,       1);
        add(0, 0,          0,            0,    0,  0,       0,   0,   0,  0,  0,  0,            0,  0,   0,       0,            0);

        foreach (vecs[i]) begin
            st_req  = vecs[i].st_req;
            st_addr = vecs[i].st_addr;
            st_data = vecs[i].st_data;
            st_be   = vecs[i].st_be;
            ld_req  = vecs[i].ld_req;
            ld_addr = vecs[i].ld_addr;
            ld_be   = vecs[i].ld_be;
            dm_ack  = vecs[i].dm_ack;
            fence   = 1'b0;
            #2;
            chk($sformatf("v%0d st_ack", i), st_ack, vecs[i].e_ack);
            chk($sformatf("v%0d st_stall", i), st_stall, vecs[i].e_stall);
            chk($sformatf("v%0d fwd_hit", i), fwd_hit, vecs[i].e_hit);
            chk($sformatf("v%0d fwd_data", i), fwd_data, vecs[i].e_fdata);
            chk($sformatf("v%0d fwd_stall", i), fwd_stall, vecs[i].e_fstall);
            chk($sformatf("v%0d dm_req", i), dm_req, vecs[i].e_dmreq);
            chk($sformatf("v%0d dm_addr", i), dm_addr, vecs[i].e_dmaddr);
            chk($sformatf("v%0d dm_data", i), dm_data, vecs[i].e_dmdata);
            chk($sformatf("v%0d count", i), count, vecs[i].e_count);
            chk($sformatf("v%0d full", i), full, vecs[i].e_count == 3'd4);
            chk($sformatf("v%0d empty", i), empty, vecs[i].e_count == 3'd0);
            chk($sformatf("v%0d fence_done", i), fence_done, 0);
            tick();
        end

        // Fence with three entries pending and dmem acking every cycle.
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 32'h700 + 32'(4 * i), 32'h70 + 32'(i), 1'b0, 1'b0);
            #2;
            chk($sformatf("fence fill%0d ack", i), st_ack, 1);
            tick();
        end
        drv(1'b0, '0, '0, 1'b1, 1'b1);
        #2;
        chk("fence pulse count", count, 3);
        chk("fence pulse done", fence_done, 0);
        tick();
        done_pulses = 0;
        for (int c = 0; c < 4; c++) begin
            drv(1'b1, 32'h7F0, 32'h7F, 1'b1, 1'b0);
            #2;
            done_pulses += int'(fence_done);
            chk($sformatf("fence c%0d stall", c), st_stall, 1);
            chk($sformatf("fence c%0d ack", c), st_ack, 0);
            chk($sformatf("fence c%0d done", c), fence_done, c == 3);
            chk($sformatf("fence c%0d count", c), count, (c < 2) ? 2 - c : 0);
            tick();
        end
        drv(1'b1, 32'h7F0, 32'h7F, 1'b0, 1'b0);
        #2;
        done_pulses += int'(fence_done);
        chk("fence resume ack", st_ack, 1);
        chk("fence done once", done_pulses, 1);
        tick();
        drv(1'b0, '0, '0, 1'b1, 1'b0);
        #2;
        chk("fence post dm_addr", dm_addr, 32'h7F0);
        tick();

        // Fence on an empty buffer: done two cycles after the pulse.
        drv(1'b0, '0, '0, 1'b0, 1'b1);
        #2;
        chk("efence t done", fence_done, 0);
        tick();
        drv(1'b1, 32'h7A0, 32'h7A, 1'b0, 1'b0);
        #2;
        chk("efence t+1 done", fence_done, 0);
        chk("efence t+1 stall", st_stall, 1);
        tick();
        drv(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        chk("efence t+2 done", fence_done, 1);
        tick();
        #2;
        chk("efence t+3 done", fence_done, 0);
        chk("efence empty", empty, 1);

        // Ten interleaved store/drain pairs across the pointer wrap.
        for (int i = 0; i <= 10; i++) begin
            drv(i < 10, 32'h400 + 32'(4 * i), 32'hD000_0000 + 32'(i), i > 0, 1'b0);
            #2;
            if (i < 10) chk($sformatf("wrap%0d ack", i), st_ack, 1);
            if (i > 0) begin
                chk($sformatf("wrap%0d dm_addr", i), dm_addr, 32'h400 + 32'(4 * (i - 1)));
                chk($sformatf("wrap%0d dm_data", i), dm_data, 32'hD000_0000 + 32'(i - 1));
            end
            chk($sformatf("wrap%0d count", i), count, (i > 0) ? 1 : 0);
            tick();
        end
        drv(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        chk("wrap end empty", empty, 1);

        // Reset mid-drain discards pending entries.
        tick();
        drv(1'b1, 32'h500, 32'h50, 1'b0, 1'b0);
        tick();
        drv(1'b1, 32'h504, 32'h54, 1'b0, 1'b0);
        tick();
        drv(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        chk("rst pre dm_req", dm_req, 1);
        chk("rst pre count", count, 2);
        rst_n = 1'b0;
        #1;
        chk("rst async dm_req", dm_req, 0);
        chk("rst async empty", empty, 1);
        chk("rst async count", count, 0);
        chk("rst async dm_addr", dm_addr, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, '0, '0, 1'b1, 1'b0);
            #2;
            chk($sformatf("rst post%0d dm_req", i), dm_req, 0);
            tick();
        end
        drv(1'b1, 32'h600, 32'h60, 1'b0, 1'b0);
        tick();
        drv(1'b0, '0, '0, 1'b1, 1'b0);
        #2;
        chk("rst new dm_addr", dm_addr, 32'h600);
        chk("rst new count", count, 1);
        tick();
        drv(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        chk("rst new drained", empty, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
